// File: rtl/addr_alloc_responder.sv
// Address-window allocator: hands out the lowest free slot address on alloc requests
// and releases slots on free requests, tracking occupancy in a slot bitmap.
module addr_alloc_responder #(
    parameter int unsigned   AW    = 64,
    parameter logic [AW-1:0] BASE  = AW'(1),
    parameter int unsigned   SLOTS = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         alloc_req_valid,
    output logic                         alloc_req_ready,
    output logic                         alloc_rsp_valid,
    input  logic                         alloc_rsp_ready,
    output logic [AW-1:0]                alloc_rsp_addr,
    output logic                         alloc_rsp_fail,
    input  logic                         free_valid,
    output logic                         free_ready,
    input  logic [AW-1:0]                free_addr,
    output logic                         free_err,
    output logic [$clog2(SLOTS+1)-1:0]   used_count
);

    localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned CW = $clog2(SLOTS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t          state;
    logic            ready_q;
    logic [SLOTS-1:0] busy;
    logic [SLOTS-1:0] busy_nxt;

    logic            found;
    logic [IW-1:0]   free_slot;
    logic [AW-1:0]   free_idx_full;
    logic [IW-1:0]   free_idx;
    logic            free_in_range;

    logic            alloc_fire;
    logic            alloc_ok;
    logic            free_fire;
    logic            free_ok;

    // Handshake readiness depends only on registered state, never on a valid input.
    assign alloc_req_ready = ready_q && (state == IDLE);
    assign free_ready      = ready_q;

    assign alloc_fire = alloc_req_valid && alloc_req_ready;
    assign alloc_ok   = alloc_fire && found;
    assign free_fire  = free_valid && free_ready;

    // Lowest-index free slot in the registered bitmap.
    always_comb begin
        found     = 1'b0;
        free_slot = '0;
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                found     = 1'b1;
                free_slot = IW'(i);
            end
        end
    end

    // Modulo subtraction; below-BASE addresses wrap high and fail the range test.
    assign free_idx_full = free_addr - BASE;
    assign free_idx      = free_idx_full[IW-1:0];
    assign free_in_range = (free_addr >= BASE) && (free_idx_full < AW'(SLOTS));
    assign free_ok       = free_fire && free_in_range && busy[free_idx];

    // Alloc only ever claims a clear bit and free only a set bit, so they never collide.
    always_comb begin
        busy_nxt = busy;
        if (alloc_ok) begin
            busy_nxt[free_slot] = 1'b1;
        end
        if (free_ok) begin
            busy_nxt[free_idx] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            ready_q         <= 1'b0;
            busy            <= '0;
            used_count      <= '0;
            alloc_rsp_valid <= 1'b0;
            alloc_rsp_addr  <= '0;
            alloc_rsp_fail  <= 1'b0;
            free_err        <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            busy       <= busy_nxt;
            used_count <= used_count + CW'(alloc_ok) - CW'(free_ok);
            free_err   <= free_fire && !free_ok;

            case (state)
                IDLE: begin
                    if (alloc_fire) begin
                        state           <= RESP;
                        alloc_rsp_valid <= 1'b1;
                        alloc_rsp_fail  <= !found;
                        alloc_rsp_addr  <= found ? (BASE + AW'(free_slot)) : '0;
                    end
                end
                RESP: begin
                    if (alloc_rsp_ready) begin
                        state           <= IDLE;
                        alloc_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    alloc_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_alloc_responder.sv
// Self-checking bench for addr_alloc_responder: directed vector table, corner-case
// sequences, and randomized traffic compared with a slot-array reference model.
module tb_addr_alloc_responder;

    localparam int unsigned   AW    = 64;
    localparam int unsigned   SLOTS = 16;
    localparam logic [AW-1:0] BASE  = 64'd1;
    localparam int unsigned   CW    = $clog2(SLOTS + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          alloc_req_valid;
    logic          alloc_req_ready;
    logic          alloc_rsp_valid;
    logic          alloc_rsp_ready;
    logic [AW-1:0] alloc_rsp_addr;
    logic          alloc_rsp_fail;
    logic          free_valid;
    logic          free_ready;
    logic [AW-1:0] free_addr;
    logic          free_err;
    logic [CW-1:0] used_count;

    int passed = 0;
    int total  = 0;

    addr_alloc_responder #(.AW(AW), .BASE(BASE), .SLOTS(SLOTS)) dut (
        .clock           (clock),
        .reset           (reset),
        .alloc_req_valid (alloc_req_valid),
        .alloc_req_ready (alloc_req_ready),
        .alloc_rsp_valid (alloc_rsp_valid),
        .alloc_rsp_ready (alloc_rsp_ready),
        .alloc_rsp_addr  (alloc_rsp_addr),
        .alloc_rsp_fail  (alloc_rsp_fail),
        .free_valid      (free_valid),
        .free_ready      (free_ready),
        .free_addr       (free_addr),
        .free_err        (free_err),
        .used_count      (used_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        av;
        logic        rr;
        logic        fv;
        logic [63:0] fa;
        logic        ev;
        logic [63:0] ea;
        logic        ef;
        int unsigned eu;
        logic        ee;
        logic        erdy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic av, input logic rr, input logic fv, input logic [63:0] fa,
                       input logic ev, input logic [63:0] ea, input logic ef,
                       input int unsigned eu, input logic ee, input logic erdy);
        vec_t v;
        v.av = av; v.rr = rr; v.fv = fv; v.fa = fa;
        v.ev = ev; v.ea = ea; v.ef = ef; v.eu = eu; v.ee = ee; v.erdy = erdy;
        vecs.push_back(v);
    endtask

    task automatic reset_dut;
        alloc_req_valid = 1'b0;
        alloc_rsp_ready = 1'b0;
        free_valid      = 1'b0;
        free_addr       = '0;
        reset           = 1'b1;
        tick();
        tick();
        check("rst_rsp_valid", 64'(alloc_rsp_valid), 64'd0);
        check("rst_rsp_addr", alloc_rsp_addr, 64'd0);
        check("rst_rsp_fail", 64'(alloc_rsp_fail), 64'd0);
        check("rst_used", 64'(used_count), 64'd0);
        check("rst_free_err", 64'(free_err), 64'd0);
        check("rst_req_ready", 64'(alloc_req_ready), 64'd0);
        check("rst_free_ready", 64'(free_ready), 64'd0);
        reset = 1'b0;
        tick();
        check("rel_req_ready", 64'(alloc_req_ready), 64'd1);
        check("rel_free_ready", 64'(free_ready), 64'd1);
    endtask

    task automatic alloc_one(input string name, input logic [63:0] ea, input logic ef,
                             input int unsigned eu);
        alloc_req_valid = 1'b1;
        alloc_rsp_ready = 1'b0;
        tick();
        alloc_req_valid = 1'b0;
        check({name, "_valid"}, 64'(alloc_rsp_valid), 64'd1);
        check({name, "_addr"}, alloc_rsp_addr, ea);
        check({name, "_fail"}, 64'(alloc_rsp_fail), 64'(ef));
        check({name, "_used"}, 64'(used_count), 64'(eu));
        alloc_rsp_ready = 1'b1;
        tick();
        alloc_rsp_ready = 1'b0;
        check({name, "_drop"}, 64'(alloc_rsp_valid), 64'd0);
        check({name, "_rdy"}, 64'(alloc_req_ready), 64'd1);
    endtask

    task automatic free_one(input string name, input logic [63:0] a, input logic ee,
                            input int unsigned eu);
        free_valid = 1'b1;
        free_addr  = a;
        tick();
        free_valid = 1'b0;
        check({name, "_err"}, 64'(free_err), 64'(ee));
        check({name, "_used"}, 64'(used_count), 64'(eu));
        tick();
        check({name, "_err_end"}, 64'(free_err), 64'd0);
    endtask

    // Reference model state for random traffic.
    bit          mb[SLOTS];
    bit          m_pend;
    logic [63:0] m_addr;
    bit          m_fail;

    initial begin
        reset_dut();

        // Back-to-back allocs with the request held high: ready gates the second cycle.
        for (int k = 0; k < 8; k++) begin
            add(1, 1, 0, 0, 1, 64'(k + 1), 0, k + 1, 0, 0);
            add(1, 1, 0, 0, 0, 64'(k + 1), 0, k + 1, 0, 1);
        end
        // Frees with slots 1..8 busy: one good free, then rejected ones each followed by a quiet cycle.
        add(0, 1, 1, 64'h3, 0, 64'h8, 0, 7, 0, 1);
        add(0, 1, 1, 64'h3, 0, 64'h8, 0, 7, 1, 1);
        add(0, 1, 0, 0,     0, 64'h8, 0, 7, 0, 1);
        add(0, 1, 1, 64'h0, 0, 64'h8, 0, 7, 1, 1);
        add(0, 1, 0, 0,     0, 64'h8, 0, 7, 0, 1);
        add(0, 1, 1, 64'h11, 0, 64'h8, 0, 7, 1, 1);
        add(0, 1, 0, 0,     0, 64'h8, 0, 7, 0, 1);
        add(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h8, 0, 7, 1, 1);
        add(0, 1, 0, 0,     0, 64'h8, 0, 7, 0, 1);
        add(0, 1, 1, 64'h10, 0, 64'h8, 0, 7, 1, 1);
        add(0, 1, 0, 0,     0, 64'h8, 0, 7, 0, 1);
        // Hole at slot 3 is reused first.
        add(1, 0, 0, 0,     1, 64'h3, 0, 8, 0, 0);
        add(0, 1, 0, 0,     0, 64'h3, 0, 8, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            alloc_req_valid = vecs[i].av;
            alloc_rsp_ready = vecs[i].rr;
            free_valid      = vecs[i].fv;
            free_addr       = vecs[i].fa;
            tick();
            check($sformatf("vec%0d_valid", i), 64'(alloc_rsp_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d_addr", i), alloc_rsp_addr, vecs[i].ea);
            check($sformatf("vec%0d_fail", i), 64'(alloc_rsp_fail), 64'(vecs[i].ef));
            check($sformatf("vec%0d_used", i), 64'(used_count), 64'(vecs[i].eu));
            check($sformatf("vec%0d_ferr", i), 64'(free_err), 64'(vecs[i].ee));
            check($sformatf("vec%0d_rdy", i), 64'(alloc_req_ready), 64'(vecs[i].erdy));
        end
        alloc_req_valid = 1'b0;
        free_valid      = 1'b0;

        // Exhaustion, failure on the 17th request, and reuse of a freed slot.
        reset_dut();
        for (int k = 0; k < 16; k++) alloc_one($sformatf("fill%0d", k), 64'(k + 1), 0, k + 1);
        alloc_one("exhaust", 64'h0, 1, 16);
        free_one("free5", 64'h5, 0, 15);
        alloc_one("reuse5", 64'h5, 0, 16);

        // Full pool: same-cycle free does not make its slot allocatable yet.
        alloc_req_valid = 1'b1;
        free_valid      = 1'b1;
        free_addr       = 64'h7;
        tick();
        alloc_req_valid = 1'b0;
        free_valid      = 1'b0;
        check("same_valid", 64'(alloc_rsp_valid), 64'd1);
        check("same_fail", 64'(alloc_rsp_fail), 64'd1);
        check("same_addr", alloc_rsp_addr, 64'd0);
        check("same_used", 64'(used_count), 64'd15);
        check("same_ferr", 64'(free_err), 64'd0);
        alloc_rsp_ready = 1'b1;
        tick();
        alloc_rsp_ready = 1'b0;
        alloc_one("after_same", 64'h7, 0, 16);

        // Backpressure with a free landing while the response is held.
        free_one("free9", 64'h9, 0, 15);
        alloc_req_valid = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            free_valid = (c == 1);
            free_addr  = 64'h4;
            tick();
            free_valid = 1'b0;
            check($sformatf("bp%0d_valid", c), 64'(alloc_rsp_valid), 64'd1);
            check($sformatf("bp%0d_addr", c), alloc_rsp_addr, 64'h9);
            check($sformatf("bp%0d_fail", c), 64'(alloc_rsp_fail), 64'd0);
            check($sformatf("bp%0d_rdy", c), 64'(alloc_req_ready), 64'd0);
            check($sformatf("bp%0d_used", c), 64'(used_count), (c >= 1) ? 64'd15 : 64'd16);
            check($sformatf("bp%0d_ferr", c), 64'(free_err), 64'd0);
        end
        alloc_req_valid = 1'b0;
        alloc_rsp_ready = 1'b1;
        tick();
        alloc_rsp_ready = 1'b0;
        alloc_one("after_bp", 64'h4, 0, 16);

        // Reset while a response is pending.
        free_one("free2", 64'h2, 0, 15);
        alloc_req_valid = 1'b1;
        tick();
        alloc_req_valid = 1'b0;
        check("pend_valid", 64'(alloc_rsp_valid), 64'd1);
        reset = 1'b1;
        tick();
        check("midrst_valid", 64'(alloc_rsp_valid), 64'd0);
        check("midrst_used", 64'(used_count), 64'd0);
        check("midrst_addr", alloc_rsp_addr, 64'd0);
        check("midrst_rdy", 64'(alloc_req_ready), 64'd0);
        check("midrst_frdy", 64'(free_ready), 64'd0);
        reset = 1'b0;
        tick();
        check("postrst_rdy", 64'(alloc_req_ready), 64'd1);
        alloc_one("postrst", 64'h1, 0, 1);

        // Randomized traffic against the slot-array model.
        reset_dut();
        foreach (mb[i]) mb[i] = 1'b0;
        m_pend = 1'b0;
        m_addr = '0;
        m_fail = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        av, rr, fv, ok, e_err;
            logic [63:0] fa;
            int          r, low, cnt;
            av = ($urandom_range(0, 99) < 60);
            rr = ($urandom_range(0, 99) < 50);
            fv = ($urandom_range(0, 99) < 45);
            r  = $urandom_range(0, 19);
            fa = (r == 19) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(r);
            alloc_req_valid = av;
            alloc_rsp_ready = rr;
            free_valid      = fv;
            free_addr       = fa;

            low = -1;
            for (int i = SLOTS - 1; i >= 0; i--) if (!mb[i]) low = i;
            ok = fv && (fa >= BASE) && (fa - BASE < 64'(SLOTS)) && mb[int'(fa - BASE)];
            e_err = fv && !ok;
            if (m_pend) begin
                if (rr) m_pend = 1'b0;
            end else if (av) begin
                m_pend = 1'b1;
                m_fail = (low < 0);
                m_addr = (low < 0) ? 64'd0 : BASE + 64'(low);
                if (low >= 0) mb[low] = 1'b1;
            end
            if (ok) mb[int'(fa - BASE)] = 1'b0;
            cnt = 0;
            foreach (mb[i]) cnt += int'(mb[i]);

            tick();
            check($sformatf("rnd%0d_valid", cyc), 64'(alloc_rsp_valid), 64'(m_pend));
            check($sformatf("rnd%0d_rdy", cyc), 64'(alloc_req_ready), 64'(!m_pend));
            check($sformatf("rnd%0d_used", cyc), 64'(used_count), 64'(cnt));
            check($sformatf("rnd%0d_ferr", cyc), 64'(free_err), 64'(e_err));
            if (m_pend) begin
                check($sformatf("rnd%0d_addr", cyc), alloc_rsp_addr, m_addr);
                check($sformatf("rnd%0d_fail", cyc), 64'(alloc_rsp_fail), 64'(m_fail));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
